// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port (I/D) arbiter in front of the shared main
// memory. Supports port locking for line fills/evictions and routes read data
// back through a fixed-latency {valid, owner} tag pipeline.
module mem_arbiter #(
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  // port I (instruction cache)
  input  logic        i_rd,
  input  logic        i_wr,
  input  logic        i_lock,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_wdata,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [15:0] i_rdata,
  // port D (data cache)
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic        d_lock,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [15:0] d_rdata,
  // memory side
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [15:0] mem_data_out,
  input  logic        mem_stall,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

  state_t state_q, state_d;
  logic   last_q;              // last winner: 0 = I, 1 = D
  logic   i_valid, d_valid;
  logic   i_bad, d_bad;
  logic   sel_i, sel_d;
  logic   rd_accept;

  logic [RD_LAT-1:0] pipe_valid;
  logic [RD_LAT-1:0] pipe_owner; // 0 = I, 1 = D
  logic              ret_valid;

  // exactly one of rd/wr makes a request; both at once is a protocol error
  assign i_valid = i_rd ^ i_wr;
  assign d_valid = d_rd ^ d_wr;
  assign i_bad   = i_rd & i_wr;
  assign d_bad   = d_rd & d_wr;

  // port selection and next-state logic
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    sel_i   = 1'b0;
    sel_d   = 1'b0;
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid && d_valid) begin
          // tie: the port that did not win last time goes first
          sel_i = last_q;
          sel_d = ~last_q;
        end else begin
          sel_i = i_valid;
          sel_d = d_valid;
        end
      end
      LOCK_I:  sel_i = i_valid;
      LOCK_D:  sel_d = d_valid;
      default: ;
    endcase
    if (rst) begin
      sel_i = 1'b0;
      sel_d = 1'b0;
    end

    i_gnt = sel_i & ~mem_stall;
    d_gnt = sel_d & ~mem_stall;

    // the owner may still be granted in the cycle its lock drops
    unique case (state_q)
      IDLE: begin
        if (i_gnt && i_lock)      state_d = LOCK_I;
        else if (d_gnt && d_lock) state_d = LOCK_D;
      end
      LOCK_I:  if (!i_lock) state_d = IDLE;
      LOCK_D:  if (!d_lock) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // selected port drives the memory bus; nothing selected drives zeros
  always_comb begin
    mem_addr    = 16'h0000;
    mem_data_in = 16'h0000;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    if (sel_i) begin
      mem_addr    = i_addr;
      mem_data_in = i_wdata;
      mem_read    = i_rd;
      mem_write   = i_wr;
    end else if (sel_d) begin
      mem_addr    = d_addr;
      mem_data_in = d_wdata;
      mem_read    = d_rd;
      mem_write   = d_wr;
    end
  end

  assign rd_accept = (i_gnt & i_rd) | (d_gnt & d_rd);

  // FSM state, fairness pointer and sticky error flag
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (i_gnt)      last_q <= 1'b0;
      else if (d_gnt) last_q <= 1'b1;
      if (i_bad || d_bad) err <= 1'b1;
    end
  end

  // read-return tag pipeline: shifts every cycle, stage 0 takes the accepted read
  always_ff @(posedge clk) begin
    if (rst) begin
      // clearing valid bits drops in-flight reads on reset
      pipe_valid <= '0;
      pipe_owner <= '0;
    end else begin
      for (int k = RD_LAT - 1; k > 0; k--) begin
        pipe_valid[k] <= pipe_valid[k-1];
        pipe_owner[k] <= pipe_owner[k-1];
      end
      pipe_valid[0] <= rd_accept;
      pipe_owner[0] <= d_gnt;
    end
  end

  // last pipeline stage steers memory read data to its owner
  assign ret_valid = pipe_valid[RD_LAT-1] & ~rst;
  assign i_rvalid  = ret_valid & ~pipe_owner[RD_LAT-1];
  assign d_rvalid  = ret_valid &  pipe_owner[RD_LAT-1];
  assign i_rdata   = i_rvalid ? mem_data_out : 16'h0000;
  assign d_rdata   = d_rvalid ? mem_data_out : 16'h0000;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, all
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rd, i_wr, i_lock, d_rd, d_wr, d_lock;
  logic [15:0] i_addr, i_wdata, d_addr, d_wdata;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [15:0] i_rdata, d_rdata;
  logic [15:0] mem_addr, mem_data_in, mem_data_out;
  logic        mem_read, mem_write, mem_stall, err;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  typedef struct {
    int due;
    int port;
  } ret_t;
  ret_t ret_q[$];
  int   lock_own = -1;   // -1 none, 0 I, 1 D
  int   last_win = 0;    // 0 I, 1 D
  bit   err_exp  = 1'b0;
  int   cyc      = 0;

  mem_arbiter #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .i_rd(i_rd), .i_wr(i_wr), .i_lock(i_lock), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_rd(d_rd), .d_wr(d_wr), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_data_out(mem_data_out), .mem_stall(mem_stall), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic clear_inputs();
    i_rd = 0; i_wr = 0; i_lock = 0; i_addr = 0; i_wdata = 0;
    d_rd = 0; d_wr = 0; d_lock = 0; d_addr = 0; d_wdata = 0;
    mem_stall = 0; rst = 0;
  endtask

  // Entered just after a rising edge with stimulus applied: checks every
  // output of this cycle against the model, advances the model, then moves
  // to just after the next rising edge.
  task automatic step();
    bit vi, vd, bad, acc, ev_i, ev_d, rd_sel, lk;
    int sel;
    logic [15:0] exp_addr, exp_wd;
    bit exp_rd, exp_wr;
    ret_t r;
    #1;
    vi  = (i_rd != i_wr);
    vd  = (d_rd != d_wr);
    bad = (i_rd && i_wr) || (d_rd && d_wr);

    sel = -1;
    if (!rst) begin
      if (lock_own == 0)      sel = vi ? 0 : -1;
      else if (lock_own == 1) sel = vd ? 1 : -1;
      else if (vi && vd)      sel = 1 - last_win;
      else if (vi)            sel = 0;
      else if (vd)            sel = 1;
    end
    acc = (sel >= 0) && !mem_stall;

    exp_addr = 16'h0; exp_wd = 16'h0; exp_rd = 0; exp_wr = 0;
    if (sel == 0) begin exp_addr = i_addr; exp_wd = i_wdata; exp_rd = i_rd; exp_wr = i_wr; end
    if (sel == 1) begin exp_addr = d_addr; exp_wd = d_wdata; exp_rd = d_rd; exp_wr = d_wr; end

    ev_i = 0; ev_d = 0;
    if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
      if (!rst) begin
        ev_i = (ret_q[0].port == 0);
        ev_d = (ret_q[0].port == 1);
      end
      void'(ret_q.pop_front());
    end

    check("i_gnt",       i_gnt,       acc && sel == 0);
    check("d_gnt",       d_gnt,       acc && sel == 1);
    check("mem_read",    mem_read,    exp_rd);
    check("mem_write",   mem_write,   exp_wr);
    check("mem_addr",    mem_addr,    exp_addr);
    check("mem_data_in", mem_data_in, exp_wd);
    check("i_rvalid",    i_rvalid,    ev_i);
    check("d_rvalid",    d_rvalid,    ev_d);
    check("i_rdata",     i_rdata,     ev_i ? mem_data_out : 16'h0);
    check("d_rdata",     d_rdata,     ev_d ? mem_data_out : 16'h0);
    check("err",         err,         err_exp);

    if (rst) begin
      lock_own = -1;
      last_win = 0;
      err_exp  = 0;
      ret_q.delete();
    end else begin
      if (bad) err_exp = 1;
      if (acc) begin
        last_win = sel;
        rd_sel = (sel == 0) ? i_rd : d_rd;
        if (rd_sel) begin
          r.due  = cyc + RD_LAT;
          r.port = sel;
          ret_q.push_back(r);
        end
      end
      if (lock_own < 0) begin
        lk = (sel == 0) ? i_lock : d_lock;
        if (acc && lk) lock_own = sel;
      end else begin
        lk = (lock_own == 0) ? i_lock : d_lock;
        if (!lk) lock_own = -1;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    mem_data_out = 16'hBEEF;
    rst = 1;
    @(posedge clk);
    #1;
    step();                       // reset cycle with known state
    rst = 0;

    // single D read
    d_rd = 1; d_addr = 16'h0040;
    step();
    clear_inputs();
    repeat (3) step();

    // tie and fairness: D, I, D, I
    i_rd = 1; d_rd = 1; i_addr = 16'h0100; d_addr = 16'h0200;
    repeat (4) step();
    clear_inputs();
    repeat (3) step();

    // stalled write held stable
    i_wr = 1; i_addr = 16'h0002; i_wdata = 16'h1234; mem_stall = 1;
    repeat (3) step();
    mem_stall = 0;
    step();
    clear_inputs();
    step();

    // D locks, I waits through a burst of D reads
    d_rd = 1; d_lock = 1; d_addr = 16'h0300; i_rd = 1; i_addr = 16'h0400;
    step();
    for (int k = 0; k < 6; k++) begin
      d_rd = (k != 2 && k != 4);
      d_addr = 16'h0301 + 16'(k);
      step();
    end
    d_lock = 0; d_rd = 0;
    repeat (2) step();
    clear_inputs();
    repeat (3) step();

    // bad request on I while D reads
    i_rd = 1; i_wr = 1; d_rd = 1;
    step();
    clear_inputs();
    repeat (3) step();

    // reset with a read in flight
    d_rd = 1;
    step();
    d_rd = 0; rst = 1;
    step();
    rst = 0;
    repeat (3) step();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      rst = ($urandom_range(0, 99) < 2);
      r = $urandom_range(0, 99);
      i_rd = (r < 40) || (r >= 98);
      i_wr = (r >= 40 && r < 70) || (r >= 98);
      r = $urandom_range(0, 99);
      d_rd = (r < 40) || (r >= 98);
      d_wr = (r >= 40 && r < 70) || (r >= 98);
      if ($urandom_range(0, 7) == 0) i_lock = ~i_lock;
      if ($urandom_range(0, 7) == 0) d_lock = ~d_lock;
      i_addr  = 16'($urandom);
      d_addr  = 16'($urandom);
      i_wdata = 16'($urandom);
      d_wdata = 16'($urandom);
      mem_stall    = ($urandom_range(0, 3) == 0);
      mem_data_out = 16'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single four-bank main memory between the instruction-cache controller (port I) and the data-cache controller (port D). It selects one request per cycle with round-robin fairness and honours memory back-pressure (`mem_stall`). Line fills and evictions can lock the memory to one port. A fixed-latency tag pipeline routes read data back to the port that issued the read.

## Interface
- `RD_LAT`, default 2: cycles from an accepted read to valid `mem_data_out`; legal range 1..4.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `i_rd`, `i_wr`  in  1 each  port I read / write request, level, held until granted.
- `i_lock`  in  1  port I requests exclusive ownership after its next accepted access.
- `i_addr`  in  16  port I word address.
- `i_wdata`  in  16  port I write data.
- `i_gnt`  out  1  port I request accepted by memory this cycle.
- `i_rvalid`  out  1  port I read data valid.
- `i_rdata`  out  16  port I read data.
- `d_rd`, `d_wr`, `d_lock`, `d_addr`, `d_wdata`, `d_gnt`, `d_rvalid`, `d_rdata`: same definitions for port D.
- `mem_addr`  out  16  address to memory.
- `mem_data_in`  out  16  write data to memory.
- `mem_read`, `mem_write`  out  1 each  memory strobes.
- `mem_data_out`  in  16  memory read data.
- `mem_stall`  in  1  memory rejects this cycle's strobe (bank busy); combinational from `mem_addr`.
- `err`  out  1  sticky protocol error flag.

## Operation
- A port request is valid when exactly one of rd/wr is high. If rd&wr are both high, the request is ignored (never selected) and `err` is set on the next edge. `err` clears only on reset.
- The state machine has three states: IDLE, LOCK_I, LOCK_D.
- IDLE:
  - If only one port has a valid request, that port is selected.
  - If both have valid requests, the port that was not the last winner is selected.
  - The `last` register resets to I, so D wins the first tie.
- LOCK_X: only port X can be selected. The other port's requests wait (gnt=0).
- The selected port drives `mem_addr`, `mem_data_in`, `mem_read` and `mem_write` combinationally. With no selection, all four are 0.
- Accept: `x_gnt = selected_x & ~mem_stall & ~rst`.
  - `last` updates only on accept.
  - A stalled request stays selected next cycle if it is still valid, so there is no re-arbitration mid-stall in LOCK; in IDLE the tie rule is re-evaluated.
- Lock transitions:
  - IDLE to LOCK_X on an accept from X with `x_lock`=1.
  - LOCK_X to IDLE on the edge where `x_lock`=0.
  - The lock does not expire while `x_lock` is held.
- Return path: an RD_LAT-deep shift register of {valid, owner}.
  - Every cycle it shifts; stage 0 loads {accepted read, owner}.
  - At the last stage: `x_rvalid = valid & owner==X` and `x_rdata = x_rvalid ? mem_data_out : 16'h0000`.
  - Writes never enter the pipeline as valid.
- Up to RD_LAT reads can be outstanding, mixed between ports. Data returns in issue order.

## Timing
- Reset values:
  - state=IDLE, `last`=I, pipeline cleared, `err`=0.
  - While `rst`=1: all gnt, rvalid and mem strobes are 0, and rdata are 0.
- Reset mid-operation: in-flight reads are discarded, and no rvalid is produced for them even if memory returns data.
- Grant latency: combinational, same cycle as the request when memory is not stalled.
- Read latency: `x_rvalid` is high exactly RD_LAT cycles after the `x_gnt` cycle of the read.
- A read and a return can occur in the same cycle, for the same or different ports.
- A lock taken by X blocks the other port starting the cycle after X's locking accept.
- LOCK_X with `x_lock`=0 and an X request in the same cycle: X may still be granted that cycle; the state returns to IDLE next.

## Test plan
- Single read: `d_rd`=1, `d_addr`=16'h0040, memory returns 16'hBEEF -> `d_gnt`=1 in cycle 0, `mem_read`=1, `d_rvalid`=1 with `d_rdata`=16'hBEEF in cycle 2; `i_rvalid` stays 0.
- Tie and fairness: both ports hold reads for 4 cycles with no stall -> grants alternate D, I, D, I; the four returns alternate owners in order, 2 cycles later each.
- Stall: `i_wr`=1, `i_addr`=16'h0002, `mem_stall`=1 for 3 cycles then 0 -> `i_gnt`=0 for 3 cycles, then 1; `mem_write`/`mem_addr`/`mem_data_in` held stable the whole time.
- Lock: D accepts with `d_lock`=1, then issues 4 reads over 6 cycles while `i_rd`=1 -> `i_gnt`=0 throughout; after `d_lock` drops, I is granted the next cycle.
- Error: `i_rd`=`i_wr`=1 for one cycle while `d_rd`=1 -> D granted, I ignored, `err`=1 from the next cycle until `rst`.
- Reset mid-flight: accept a D read, assert `rst` the following cycle -> no `d_rvalid`, state IDLE, all outputs 0 during reset.
